// File: rtl/obi_arb_pkg.sv
// Shared definitions for the OBI round-robin arbiter.
//   id_width    : bits needed to name one master (at least 1)
//   cnt_width   : bits needed to count 0..MaxOutstanding in-flight transactions
//   byte_parity : even parity per byte of the low 32 write-data bits, as the
//                 7-bit integrity field (upper 3 bits zero)
package obi_arb_pkg;

  localparam int IntgWidth = 7;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic logic [IntgWidth-1:0] byte_parity(input logic [31:0] d);
    return {3'b000, ^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Synchronous FIFO holding the master index of every granted, not yet
// answered transaction, so responses can be routed back in order.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/count only)
//   push, wdata   enqueue one ID (ignored when full)
//   pop           dequeue the head ID (ignored when empty)
//   rdata         current head ID
//   full, empty   occupancy flags
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = (Depth <= 1) ? 1 : $clog2(Depth);
  localparam int CntW = cnt_width(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (int'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter with round-robin selection.
// Grants are combinational (zero added latency); each granted master index is
// queued so that responses, which return in order, are steered to their issuer.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_req_i/m_gnt_o/m_rvalid_o   per-master handshake
//   m_we_i/m_be_i/m_addr_i/m_wdata_i  per-master request payload (packed)
//   m_rdata_o                    slave read data broadcast to all masters
//   s_req_o/s_gnt_i/s_rvalid_i   slave handshake
//   s_we_o/s_be_o/s_addr_o/s_wdata_o  payload of the selected master
//   s_wdata_intg_o               write-data integrity bits
//   s_rdata_i                    slave read data
//   busy_o                       transactions in flight
//   err_o                        sticky: response arrived with nothing in flight
// Build option: define OBI_ARB_INTG_EN to drive per-byte even parity on
// s_wdata_intg_o; otherwise it is tied to zero.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NumMasters     = 2,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumMasters-1:0]             m_req_i,
  output logic [NumMasters-1:0]             m_gnt_o,
  output logic [NumMasters-1:0]             m_rvalid_o,
  input  logic [NumMasters-1:0]             m_we_i,
  input  logic [NumMasters*DataWidth/8-1:0] m_be_i,
  input  logic [NumMasters*AddrWidth-1:0]   m_addr_i,
  input  logic [NumMasters*DataWidth-1:0]   m_wdata_i,
  output logic [NumMasters*DataWidth-1:0]   m_rdata_o,
  output logic                              s_req_o,
  input  logic                              s_gnt_i,
  input  logic                              s_rvalid_i,
  output logic                              s_we_o,
  output logic [DataWidth/8-1:0]            s_be_o,
  output logic [AddrWidth-1:0]              s_addr_o,
  output logic [DataWidth-1:0]              s_wdata_o,
  output logic [IntgWidth-1:0]              s_wdata_intg_o,
  input  logic [DataWidth-1:0]              s_rdata_i,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int IdW = id_width(NumMasters);
  localparam int BeW = DataWidth / 8;

  logic [IdW-1:0]        rr_ptr;
  logic                  lock_q;
  logic [IdW-1:0]        lock_idx;
  logic [IdW-1:0]        arb_idx;
  logic [IdW-1:0]        sel;
  logic [IdW-1:0]        head;
  logic [NumMasters-1:0] sel_oh;
  logic [NumMasters-1:0] head_oh;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  handshake;
  logic                  pop;
  logic                  err_q;

  function automatic logic [IdW-1:0] next_idx(input logic [IdW-1:0] i);
    return (int'(i) == NumMasters - 1) ? '0 : i + IdW'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int  j;
    logic found;
    arb_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NumMasters; k++) begin
      j = (int'(rr_ptr) + k) % NumMasters;
      if (!found && m_req_i[j]) begin
        found   = 1'b1;
        arb_idx = IdW'(j);
      end
    end
  end

  // A request stalled by the slave keeps its master so the payload stays stable.
  assign sel       = lock_q ? lock_idx : arb_idx;
  assign sel_oh    = NumMasters'(1) << sel;
  assign head_oh   = NumMasters'(1) << head;

  // Full blocks new requests even if a response pops in the same cycle.
  assign s_req_o   = (|m_req_i) && !fifo_full;
  assign handshake = s_req_o && s_gnt_i;
  assign pop       = s_rvalid_i && !fifo_empty;

  assign m_gnt_o    = handshake ? sel_oh : '0;
  assign m_rvalid_o = pop ? head_oh : '0;
  assign m_rdata_o  = {NumMasters{s_rdata_i}};

  assign s_we_o    = s_req_o ? m_we_i[sel] : 1'b0;
  assign s_be_o    = s_req_o ? m_be_i[int'(sel)*BeW +: BeW] : '0;
  assign s_addr_o  = s_req_o ? m_addr_i[int'(sel)*AddrWidth +: AddrWidth] : '0;
  assign s_wdata_o = s_req_o ? m_wdata_i[int'(sel)*DataWidth +: DataWidth] : '0;

`ifdef OBI_ARB_INTG_EN
  logic [DataWidth+31:0] wdata_ext;
  assign wdata_ext      = {32'b0, s_wdata_o};
  assign s_wdata_intg_o = byte_parity(wdata_ext[31:0]);
`else
  assign s_wdata_intg_o = '0;
`endif

  assign busy_o = !fifo_empty;
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= next_idx(sel);
        lock_q <= 1'b0;
      end else if (s_req_o) begin
        lock_q <= 1'b1;
      end
      if (s_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_req_o && !s_gnt_i && !lock_q) begin
      lock_idx <= sel;
    end
  end

  obi_arb_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (handshake),
    .wdata (sel),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;
  localparam int N  = 2;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      m_req, m_gnt, m_rvalid, m_we;
  logic [AW-1:0]     addr  [N];
  logic [DW-1:0]     wdata [N];
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*DW/8-1:0] m_be;
  logic [N*DW-1:0]   m_rdata;
  logic              s_req, s_gnt, s_rvalid, s_we;
  logic [DW/8-1:0]   s_be;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [6:0]        s_intg;
  logic              busy, err;

  assign m_addr  = {addr[1], addr[0]};
  assign m_wdata = {wdata[1], wdata[0]};
  assign m_be    = '0;
  assign m_we    = '0;

  obi_rr_arbiter #(
    .NumMasters(N), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
    .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_wdata_intg_o(s_intg), .s_rdata_i(s_rdata),
    .busy_o(busy), .err_o(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model and response scoreboard, evaluated on the falling edge.
  int   exp_q[$];
  int   m_rr, m_lock_idx, e_sel, id;
  bit   m_lock, m_err, e_full, e_sreq, e_hs, found;

  always @(negedge clk) begin
    if (rst) begin
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
      exp_q.delete();
    end else begin
      e_full = (exp_q.size() >= MO);
      e_sreq = (|m_req) && !e_full;
      if (m_lock) begin
        e_sel = m_lock_idx;
      end else begin
        e_sel = 0; found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && m_req[(m_rr + k) % N]) begin
            found = 1; e_sel = (m_rr + k) % N;
          end
        end
      end
      e_hs = e_sreq && s_gnt;
      check("sb_sreq",  s_req,   e_sreq);
      check("sb_gnt",   m_gnt,   e_hs ? (1 << e_sel) : 0);
      check("sb_addr",  s_addr,  e_sreq ? addr[e_sel] : 0);
      check("sb_wdata", s_wdata, e_sreq ? wdata[e_sel] : 0);
      check("sb_busy",  busy,    exp_q.size() != 0);
      check("sb_err",   err,     m_err);
      if (s_rvalid && exp_q.size() != 0) begin
        id = exp_q.pop_front();
        check("sb_rvalid", m_rvalid, 1 << id);
        check("sb_rdata",  m_rdata[id*DW +: DW], s_rdata);
      end else begin
        check("sb_rvalid", m_rvalid, 0);
        if (s_rvalid) m_err = 1;
      end
      if (e_hs) begin
        exp_q.push_back(e_sel);
        m_rr   = (e_sel + 1) % N;
        m_lock = 0;
      end else if (e_sreq) begin
        m_lock = 1; m_lock_idx = e_sel;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; m_req = '0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #3;
    check("rst_sreq", s_req, 0);
    check("rst_gnt",  m_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_err",  err, 0);
    check("rst_addr", s_addr, 0);
    check("rst_intg", s_intg, 0);

    // Both masters requesting, slave always granting: grants alternate.
    addr[0] = 32'h0000_0010; addr[1] = 32'h0000_0020;
    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      cyc(); m_req = 2'b11; s_gnt = 1; s_rvalid = (i > 0); s_rdata = 32'h100 + i;
      #3;
      check("t1_gnt", m_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check("t1_rv", m_rvalid, (i % 2 == 1) ? 2'b01 : 2'b10);
    end
    cyc(); m_req = 2'b00; s_gnt = 0; s_rvalid = 1; #3;
    check("t1_rv_last", m_rvalid, 2'b10);
    cyc(); s_rvalid = 0;

    // Stalled M1 keeps the bus while M0 also asks.
    addr[1] = 32'h100; addr[0] = 32'h200;
    cyc(); m_req = 2'b10; s_gnt = 0; #3;
    check("t2_addr0", s_addr, 32'h100);
    check("t2_gnt0",  m_gnt, 2'b00);
    for (int i = 0; i < 2; i++) begin
      cyc(); m_req = 2'b11; #3;
      check("t2_addr_hold", s_addr, 32'h100);
      check("t2_gnt_hold",  m_gnt, 2'b00);
    end
    cyc(); s_gnt = 1; #3;
    check("t2_gnt_m1",  m_gnt, 2'b10);
    check("t2_addr_m1", s_addr, 32'h100);
    cyc(); #3;
    check("t2_gnt_m0",  m_gnt, 2'b01);
    check("t2_addr_m0", s_addr, 32'h200);
    cyc(); m_req = 2'b00; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hA5A5_A5A5; #3;
    check("t2_rv_m1", m_rvalid, 2'b10);
    cyc(); s_rdata = 32'h5A5A_5A5A; #3;
    check("t2_rv_m0",   m_rvalid, 2'b01);
    check("t2_rdata_0", m_rdata[DW-1:0], 32'h5A5A_5A5A);
    cyc(); s_rvalid = 0;

    // Fill to MaxOutstanding, then ordered responses reopen the port.
    cyc(); m_req = 2'b01; s_gnt = 1; #3;
    check("t3_gnt_m0", m_gnt, 2'b01);
    cyc(); m_req = 2'b10; #3;
    check("t3_gnt_m1", m_gnt, 2'b10);
    cyc(); m_req = 2'b11; #3;
    check("t3_full_sreq", s_req, 0);
    check("t3_full_gnt",  m_gnt, 2'b00);
    check("t3_full_busy", busy, 1);
    cyc(); s_rvalid = 1; s_rdata = 32'hA5A5_A5A5; #3;
    check("t3_poppush_sreq", s_req, 0);
    check("t4_rv_m0",    m_rvalid, 2'b01);
    check("t4_rdata_m0", m_rdata[DW-1:0], 32'hA5A5_A5A5);
    cyc(); s_rdata = 32'h5A5A_5A5A; #3;
    check("t4_rv_m1",    m_rvalid, 2'b10);
    check("t4_rdata_m1", m_rdata[2*DW-1:DW], 32'h5A5A_5A5A);
    check("t3_reopen",   s_req, 1);
    check("t3_gnt_again", m_gnt, 2'b01);
    cyc(); m_req = 2'b00; s_gnt = 0; s_rdata = 32'h1234_5678; #3;
    check("t3_rv_drain", m_rvalid, 2'b01);
    cyc(); s_rvalid = 0; #3;
    check("t3_idle_busy", busy, 0);

    // Integrity bits for write data 0x01030007.
    wdata[0] = 32'h0103_0007;
    cyc(); m_req = 2'b01; s_gnt = 0; #3;
`ifdef OBI_ARB_INTG_EN
    check("t6_intg", s_intg, 7'b0001001);
`else
    check("t6_intg", s_intg, 7'b0000000);
`endif
    cyc(); s_gnt = 1; #3;
    check("t6_gnt", m_gnt, 2'b01);
    cyc(); m_req = 2'b00; s_gnt = 0; s_rvalid = 1; #3;
    check("t6_rv", m_rvalid, 2'b01);
    cyc(); s_rvalid = 0;

    // Response with nothing in flight sets a sticky error.
    cyc(); s_rvalid = 1; #3;
    check("t5_rv_none", m_rvalid, 2'b00);
    check("t5_err_pre", err, 0);
    cyc(); s_rvalid = 0; #3;
    check("t5_err_set", err, 1);
    repeat (3) cyc();
    #3;
    check("t5_err_sticky", err, 1);
    cyc(); rst = 1;
    cyc(); rst = 0; #3;
    check("t5_err_clr", err, 0);

    // Reset while a transaction is outstanding drops its ID.
    cyc(); m_req = 2'b01; s_gnt = 1; #3;
    check("t7_gnt", m_gnt, 2'b01);
    cyc(); m_req = 2'b00; s_gnt = 0; rst = 1;
    cyc(); rst = 0; #3;
    check("t7_busy", busy, 0);
    cyc(); s_rvalid = 1; #3;
    check("t7_rv_late", m_rvalid, 2'b00);
    cyc(); s_rvalid = 0; #3;
    check("t7_err", err, 1);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
